env_det_serial_tx: RTL and testbench
====================================

ENV_DET_SERIAL_TX -- requirements
Module: env_det_serial_tx

Interface
REQ-001 Parameter DATA_W, default 9, payload bits per frame (range 5..16).
REQ-002 Parameter CLKS_PER_BIT, default 139, CLK cycles per serial bit (>=2).
REQ-003 Parameter DEBOUNCE_CYC, default 16, consecutive stable cycles needed to accept a detect-level change (>=1).
REQ-004 Parameter PWR_ON_DLY, default 1024, cycles from pwr_en rise to ready (>=1).
REQ-005 Parameter PARITY_EN, default 0; 1 inserts an even-parity bit after the data bits.
REQ-006 CLK  input  1  sole clock, all state on rising edge.
REQ-007 RST  input  1  asynchronous, active-high reset.
REQ-008 det_in  input  1  raw, asynchronous environment-detect pin.
REQ-009 tx_data  input  DATA_W  word to transmit.
REQ-010 tx_valid  input  1  tx_data is valid.
REQ-011 tx_ready  output  1  block accepts a word this cycle.
REQ-012 tx  output  1  serial line, idle high.
REQ-013 pwr_en  output  1  external power enable.
REQ-014 det  output  1  debounced detect level (LED drive).
REQ-015 busy  output  1  frame in progress.

Function
REQ-016 det_in SHALL pass through a 2-flop synchroniser; det SHALL change only after the synchronised value differs from det for DEBOUNCE_CYC consecutive cycles, so total latency is 2+DEBOUNCE_CYC cycles; any bounce restarts the count.
REQ-017 FSM states SHALL be OFF, PWR_WAIT, IDLE, START, DATA, PARITY, STOP.
REQ-018 OFF: pwr_en=0, tx=1; on det=1 go to PWR_WAIT.
REQ-019 PWR_WAIT: pwr_en=1; after exactly PWR_ON_DLY cycles go to IDLE; det=0 at any point returns to OFF the next cycle.
REQ-020 IDLE: pwr_en=1, tx_ready=1, tx=1; tx_ready SHALL be 0 in every other state.
REQ-021 Handshake: word accepted on a rising edge where tx_valid&&tx_ready; tx_data latched then, ignored thereafter; next cycle state START, tx=0, busy=1.
REQ-022 Each of START, every DATA bit, PARITY, STOP SHALL hold tx for exactly CLKS_PER_BIT cycles.
REQ-023 DATA SHALL send tx_data LSB first, DATA_W bits, using an internal bit index of ceil(log2(DATA_W)) bits.
REQ-024 PARITY (only if PARITY_EN=1): tx = XOR of the DATA_W latched bits.
REQ-025 STOP: tx=1; frame length = (DATA_W+2+PARITY_EN)*CLKS_PER_BIT cycles, busy high for all of it.
REQ-026 After STOP: det=1 -> IDLE (tx_ready=1 on the next cycle, back-to-back frames allowed); det=0 -> OFF.
REQ-027 det falling during START/DATA/PARITY/STOP SHALL NOT abort the frame; pwr_en stays 1 until STOP completes.
REQ-028 det falling in IDLE SHALL go to OFF next cycle, dropping pwr_en and tx_ready simultaneously.
REQ-029 tx_valid held high with no handshake SHALL have no effect outside IDLE.
REQ-030 tx SHALL be registered (glitch-free).

Reset
REQ-031 While RST=1: state OFF, tx=1, pwr_en=0, det=0, tx_ready=0, busy=0, synchroniser/debounce/baud/bit/delay counters 0.
REQ-032 RST assertion mid-frame SHALL immediately force tx=1 and the REQ-031 values; no partial frame resumes after release.
REQ-033 After RST release the block SHALL re-run debounce and PWR_WAIT before tx_ready.

Verification (DATA_W=9, CLKS_PER_BIT=4, DEBOUNCE_CYC=3, PWR_ON_DLY=5)
REQ-034 det_in 0->1 held -> det=1 after 5 cycles, pwr_en=1 next cycle, tx_ready=1 exactly 5 cycles later.
REQ-035 det_in pulses high 2 cycles then low -> det, pwr_en stay 0.
REQ-036 Send 0x1A5, PARITY_EN=0 -> tx = 0,1,0,1,0,0,1,0,1,1,1 each 4 cycles (44 cycles), busy high 44 cycles, tx_ready back next cycle.
REQ-037 PARITY_EN=1, send 0x0FF -> 8 ones, parity bit 0, frame 48 cycles.
REQ-038 det_in drops mid-DATA -> frame completes intact, then pwr_en=0, state OFF.
REQ-039 RST pulse mid-frame -> tx=1, pwr_en=0 same cycle; no further bits; tx_ready only after full detect and power-up sequence.

Source files
------------

// File: rtl/env_det_serial_tx_if.sv
// Transmit handshake bundle for env_det_serial_tx: word, valid qualifier and ready.
interface env_det_serial_tx_if #(
    parameter int DATA_W = 9
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/env_det_serial_tx.sv
// Environment-detect gated serial transmitter: debounced detect powers the link up,
// then words are framed (start, LSB-first data, optional even parity, stop).
module env_det_serial_tx #(
    parameter int DATA_W       = 9,
    parameter int CLKS_PER_BIT = 139,
    parameter int DEBOUNCE_CYC = 16,
    parameter int PWR_ON_DLY   = 1024,
    parameter int PARITY_EN    = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                det_in,
    env_det_serial_tx_if.slave  txif,
    output logic                tx,
    output logic                pwr_en,
    output logic                det,
    output logic                busy
);

    localparam int IDX_W  = $clog2(DATA_W);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int DLY_W  = $clog2(PWR_ON_DLY + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_W - 1);
    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [DB_W-1:0]   LAST_DB   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DLY_W-1:0]  LAST_DLY  = DLY_W'(PWR_ON_DLY - 1);

    if (DATA_W < 5 || DATA_W > 16) begin : g_bad_data_w
        $error("env_det_serial_tx: DATA_W must be 5..16");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("env_det_serial_tx: CLKS_PER_BIT must be >= 2");
    end
    if (DEBOUNCE_CYC < 1 || PWR_ON_DLY < 1) begin : g_bad_dly
        $error("env_det_serial_tx: DEBOUNCE_CYC and PWR_ON_DLY must be >= 1");
    end

    typedef enum logic [2:0] {
        OFF,
        PWR_WAIT,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    logic              sync1_q, sync2_q;
    logic              det_q, det_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              tx_q, tx_d;
    logic              baud_done;
    logic              in_frame;

    // Synchroniser and debounce: det follows sync2 only after DEBOUNCE_CYC differing cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            det_q    <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= det_in;
            sync2_q  <= sync1_q;
            det_q    <= det_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    always_comb begin
        det_d    = det_q;
        db_cnt_d = '0;
        if (sync2_q != det_q) begin
            if (db_cnt_q == LAST_DB) begin
                det_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= OFF;
            baud_q  <= '0;
            idx_q   <= '0;
            dly_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign baud_done = (baud_q == LAST_BAUD);
    assign in_frame  = (state_q == START) || (state_q == DATA) ||
                       (state_q == PARITY) || (state_q == STOP);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        data_d  = data_q;

        // One shared bit timer for every frame state; it wraps as the state advances.
        if (in_frame) begin
            baud_d = baud_done ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            OFF: begin
                dly_d = '0;
                if (det_q) begin
                    state_d = PWR_WAIT;
                end
            end
            PWR_WAIT: begin
                if (!det_q) begin
                    state_d = OFF;
                    dly_d   = '0;
                end else if (dly_q == LAST_DLY) begin
                    state_d = IDLE;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            IDLE: begin
                // An offered word wins over a same-cycle detect loss: ready was already high.
                if (txif.tx_valid) begin
                    data_d  = txif.tx_data;
                    baud_d  = '0;
                    state_d = START;
                end else if (!det_q) begin
                    state_d = OFF;
                end
            end
            START: begin
                if (baud_done) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_done) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_done) begin
                    state_d = det_q ? IDLE : OFF;
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
    end

    // Line level is computed from the next state so tx changes on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
            PARITY:  tx_d = ^data_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx            = tx_q;
    assign det           = det_q;
    assign pwr_en        = (state_q != OFF);
    assign busy          = in_frame;
    assign txif.tx_ready = (state_q == IDLE);

endmodule

// File: tb/tb_env_det_serial_tx.sv
// Bench for env_det_serial_tx: detect/debounce, power-up, framing with and without parity,
// detect loss mid-frame and reset mid-frame, checked against a per-cycle expected-line queue.
module tb_env_det_serial_tx;

    localparam int DW  = 9;
    localparam int CPB = 4;
    localparam int DB  = 3;
    localparam int PD  = 5;

    logic CLK = 1'b0;
    logic RST;
    logic det_in;
    logic tx_a, pwr_a, det_a, busy_a;
    logic tx_b, pwr_b, det_b, busy_b;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic exp_q[$];

    env_det_serial_tx_if #(.DATA_W(DW)) if_a ();
    env_det_serial_tx_if #(.DATA_W(DW)) if_b ();

    env_det_serial_tx #(
        .DATA_W(DW), .CLKS_PER_BIT(CPB), .DEBOUNCE_CYC(DB), .PWR_ON_DLY(PD), .PARITY_EN(0)
    ) dut_a (
        .CLK(CLK), .RST(RST), .det_in(det_in), .txif(if_a),
        .tx(tx_a), .pwr_en(pwr_a), .det(det_a), .busy(busy_a)
    );

    env_det_serial_tx #(
        .DATA_W(DW), .CLKS_PER_BIT(CPB), .DEBOUNCE_CYC(DB), .PWR_ON_DLY(PD), .PARITY_EN(1)
    ) dut_b (
        .CLK(CLK), .RST(RST), .det_in(det_in), .txif(if_b),
        .tx(tx_b), .pwr_en(pwr_b), .det(det_b), .busy(busy_b)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (checks %0d passed %0d)", n_checks, n_pass);
        $fatal(1, "watchdog");
    end

    // Push the expected line level for every cycle of the frame, then hand the word over.
    task automatic send_word(input bit sel, input logic [DW-1:0] w);
        for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
        for (int b = 0; b < DW; b++)
            for (int k = 0; k < CPB; k++) exp_q.push_back(w[b]);
        if (sel)
            for (int k = 0; k < CPB; k++) exp_q.push_back(^w);
        for (int k = 0; k < CPB; k++) exp_q.push_back(1'b1);
        if (sel) begin
            if_b.tx_data = w; if_b.tx_valid = 1'b1;
        end else begin
            if_a.tx_data = w; if_a.tx_valid = 1'b1;
        end
        @(posedge CLK); #1;
        if (sel) begin
            if_b.tx_valid = 1'b0; if_b.tx_data = ~w;
        end else begin
            if_a.tx_valid = 1'b0; if_a.tx_data = ~w;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; det_in = 1'b0;
        if_a.tx_valid = 1'b0; if_a.tx_data = '0;
        if_b.tx_valid = 1'b0; if_b.tx_data = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if ({tx_a, pwr_a, det_a, if_a.tx_ready, busy_a} !== 5'b10000)
            $display("FAIL reset_a: got tx/pwr/det/rdy/busy=%b want 10000",
                     {tx_a, pwr_a, det_a, if_a.tx_ready, busy_a});
        else n_pass++;
        n_checks++;
        if ({tx_b, pwr_b, det_b, if_b.tx_ready, busy_b} !== 5'b10000)
            $display("FAIL reset_b: got tx/pwr/det/rdy/busy=%b want 10000",
                     {tx_b, pwr_b, det_b, if_b.tx_ready, busy_b});
        else n_pass++;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_bounce;
        // Short pulse with tx_valid asserted while OFF: nothing may happen.
        det_in = 1'b1; if_a.tx_valid = 1'b1; if_a.tx_data = 9'h155;
        repeat (2) @(posedge CLK);
        #1 det_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({det_a, pwr_a, tx_a, busy_a, if_a.tx_ready} !== 5'b00100)
                $display("FAIL bounce cyc %0d: got det/pwr/tx/busy/rdy=%b want 00100",
                         i, {det_a, pwr_a, tx_a, busy_a, if_a.tx_ready});
            else n_pass++;
        end
        if_a.tx_valid = 1'b0;
    endtask

    task automatic test_detect;
        @(posedge CLK); #1;
        det_in = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge CLK); @(negedge CLK);
            n_checks++;
            if (det_a !== logic'(i >= DB + 2))
                $display("FAIL detect_det cyc %0d: got %b want %b", i, det_a, logic'(i >= DB + 2));
            else n_pass++;
            n_checks++;
            if (pwr_a !== logic'(i >= DB + 3))
                $display("FAIL detect_pwr cyc %0d: got %b want %b", i, pwr_a, logic'(i >= DB + 3));
            else n_pass++;
            n_checks++;
            if (if_a.tx_ready !== logic'(i >= DB + 3 + PD))
                $display("FAIL detect_rdy cyc %0d: got %b want %b", i, if_a.tx_ready,
                         logic'(i >= DB + 3 + PD));
            else n_pass++;
        end
        n_checks++;
        if ({pwr_b, if_b.tx_ready} !== 2'b11)
            $display("FAIL detect_b: got pwr/rdy=%b want 11", {pwr_b, if_b.tx_ready});
        else n_pass++;
    endtask

    task automatic test_frame;
        int  n;
        logic e;
        send_word(1'b0, 9'h1A5);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            e = exp_q.pop_front();
            n_checks++;
            if (tx_a !== e) $display("FAIL frame_tx cyc %0d: got %b want %b", i, tx_a, e);
            else n_pass++;
            n_checks++;
            if ({busy_a, if_a.tx_ready, pwr_a} !== 3'b101)
                $display("FAIL frame_flags cyc %0d: got busy/rdy/pwr=%b want 101",
                         i, {busy_a, if_a.tx_ready, pwr_a});
            else n_pass++;
        end
        @(negedge CLK);
        n_checks++;
        if ({busy_a, if_a.tx_ready, tx_a} !== 3'b011)
            $display("FAIL frame_end: got busy/rdy/tx=%b want 011", {busy_a, if_a.tx_ready, tx_a});
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] words [2];
        int   n;
        logic e;
        words[0] = 9'h0F3;
        words[1] = 9'h10C;
        for (int f = 0; f < 2; f++) begin
            send_word(1'b0, words[f]);
            n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                @(negedge CLK);
                e = exp_q.pop_front();
                n_checks++;
                if ({tx_a, busy_a} !== {e, 1'b1})
                    $display("FAIL b2b frame %0d cyc %0d: got tx/busy=%b want %b%b",
                             f, i, {tx_a, busy_a}, e, 1'b1);
                else n_pass++;
            end
            @(negedge CLK);
            n_checks++;
            if ({busy_a, if_a.tx_ready} !== 2'b01)
                $display("FAIL b2b_end frame %0d: got busy/rdy=%b want 01", f, {busy_a, if_a.tx_ready});
            else n_pass++;
        end
    endtask

    task automatic test_parity;
        logic [DW-1:0] words [2];
        int   n;
        logic e;
        words[0] = 9'h0FF;
        words[1] = 9'h007;
        for (int f = 0; f < 2; f++) begin
            send_word(1'b1, words[f]);
            n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                @(negedge CLK);
                e = exp_q.pop_front();
                n_checks++;
                if ({tx_b, busy_b} !== {e, 1'b1})
                    $display("FAIL parity frame %0d cyc %0d: got tx/busy=%b want %b%b",
                             f, i, {tx_b, busy_b}, e, 1'b1);
                else n_pass++;
            end
            @(negedge CLK);
            n_checks++;
            if ({busy_b, if_b.tx_ready, tx_b} !== 3'b011)
                $display("FAIL parity_end frame %0d: got busy/rdy/tx=%b want 011",
                         f, {busy_b, if_b.tx_ready, tx_b});
            else n_pass++;
        end
    endtask

    task automatic test_det_drop;
        int   n;
        logic e;
        send_word(1'b0, 9'h055);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            e = exp_q.pop_front();
            n_checks++;
            if ({tx_a, busy_a, pwr_a} !== {e, 2'b11})
                $display("FAIL drop cyc %0d: got tx/busy/pwr=%b want %b11", i, {tx_a, busy_a, pwr_a}, e);
            else n_pass++;
            if (i == 10) det_in = 1'b0;
        end
        @(negedge CLK);
        n_checks++;
        if ({pwr_a, if_a.tx_ready, busy_a, tx_a, det_a} !== 5'b00010)
            $display("FAIL drop_end: got pwr/rdy/busy/tx/det=%b want 00010",
                     {pwr_a, if_a.tx_ready, busy_a, tx_a, det_a});
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        bit   got;
        logic e;
        det_in = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            if (if_a.tx_ready === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (!got) $display("FAIL rst_wait_ready: got rdy=%b want 1 within 40 cycles", if_a.tx_ready);
        else n_pass++;
        send_word(1'b0, 9'h0A0);
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            e = exp_q.pop_front();
            n_checks++;
            if (tx_a !== e) $display("FAIL rst_pre cyc %0d: got %b want %b", i, tx_a, e);
            else n_pass++;
        end
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if ({tx_a, pwr_a, busy_a, if_a.tx_ready, det_a} !== 5'b10000)
            $display("FAIL rst_async: got tx/pwr/busy/rdy/det=%b want 10000",
                     {tx_a, pwr_a, busy_a, if_a.tx_ready, det_a});
        else n_pass++;
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge CLK); @(negedge CLK);
            n_checks++;
            if ({tx_a, busy_a} !== 2'b10)
                $display("FAIL rst_post_line cyc %0d: got tx/busy=%b want 10", i, {tx_a, busy_a});
            else n_pass++;
            n_checks++;
            if ({pwr_a, if_a.tx_ready} !== {logic'(i >= DB + 3), logic'(i >= DB + 3 + PD)})
                $display("FAIL rst_post_seq cyc %0d: got pwr/rdy=%b want %b%b", i, {pwr_a, if_a.tx_ready},
                         logic'(i >= DB + 3), logic'(i >= DB + 3 + PD));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_detect();
        test_frame();
        test_back_to_back();
        test_parity();
        test_det_drop();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
